// File: rtl/dmem_boot_ctrl_pkg.sv
// Shared types and constants for the data-memory boot/load controller.
package boot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } boot_state_e;

  localparam int unsigned WORD_BYTES          = 4;
  localparam int          DEFAULT_RELEASE_DLY = 4;

endpackage

// File: rtl/dmem_boot_ctrl_if.sv
// Host word stream plus the data-memory external write port driven by the boot controller.
interface dmem_boot_ctrl_if;

  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        ext_memwrite;
  logic [31:0] ext_dataadr;
  logic [31:0] ext_writedata;

  modport master (
    input  s_valid, s_data,
    output s_ready, ext_memwrite, ext_dataadr, ext_writedata
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, ext_memwrite, ext_dataadr, ext_writedata
  );

endinterface

// File: rtl/dmem_boot_ctrl.sv
// Boot sequencer: holds the CPU in reset, streams host words into data memory,
// waits a settle delay, then releases the CPU until halted.
module dmem_boot_ctrl
  import boot_pkg::*;
#(
  parameter int RELEASE_DLY = DEFAULT_RELEASE_DLY,
  parameter int LEN_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic [31:0]          base_addr,
  input  logic                 abort,
  input  logic                 halt,
  dmem_boot_ctrl_if.master     bus,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [LEN_W-1:0]     words_loaded,
  output logic [31:0]          checksum
);

  localparam int                  SETTLE_W    = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(RELEASE_DLY - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [LEN_W-1:0]    WORD_ONE    = LEN_W'(1);

  boot_state_e         state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [31:0]         base_q, base_d;
  logic [LEN_W-1:0]    words_q, words_d;
  logic [31:0]         sum_q, sum_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                s_ready_q, s_ready_d;
  logic                memwrite_q, memwrite_d;
  logic [31:0]         dataadr_q, dataadr_d;
  logic [31:0]         writedata_q, writedata_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                hs;

  // abort must veto a handshake in its own cycle, so it masks the registered ready.
  assign hs = bus.s_valid & s_ready_q & ~abort;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    base_d      = base_q;
    words_d     = words_q;
    sum_d       = sum_q;
    settle_d    = settle_q;
    s_ready_d   = s_ready_q;
    memwrite_d  = 1'b0;
    dataadr_d   = dataadr_q;
    writedata_d = writedata_q;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d    = len;
          base_d   = base_addr & ~32'h3;
          words_d  = '0;
          sum_d    = '0;
          err_d    = 1'b0;
          settle_d = '0;
          busy_d   = 1'b1;
          if (len != '0) begin
            state_d   = ST_LOAD;
            s_ready_d = 1'b1;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d   = ST_IDLE;
          err_d     = 1'b1;
          s_ready_d = 1'b0;
          busy_d    = 1'b0;
        end else if (hs) begin
          memwrite_d  = 1'b1;
          dataadr_d   = base_q + 32'(words_q) * WORD_BYTES;
          writedata_d = bus.s_data;
          words_d     = words_q + WORD_ONE;
          sum_d       = sum_q + bus.s_data;
          if ((words_q + WORD_ONE) == len_q) begin
            state_d   = ST_SETTLE;
            s_ready_d = 1'b0;
            settle_d  = '0;
          end
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d     = ST_RUN;
          cpu_reset_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          settle_d = settle_q + SETTLE_ONE;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_d     = ST_IDLE;
          cpu_reset_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cpu_reset_d = 1'b1;
        s_ready_d   = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      base_q      <= '0;
      words_q     <= '0;
      sum_q       <= '0;
      settle_q    <= '0;
      s_ready_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      dataadr_q   <= '0;
      writedata_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      base_q      <= base_d;
      words_q     <= words_d;
      sum_q       <= sum_d;
      settle_q    <= settle_d;
      s_ready_q   <= s_ready_d;
      memwrite_q  <= memwrite_d;
      dataadr_q   <= dataadr_d;
      writedata_q <= writedata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.s_ready       = s_ready_q & ~abort;
  assign bus.ext_memwrite  = memwrite_q;
  assign bus.ext_dataadr   = dataadr_q;
  assign bus.ext_writedata = writedata_q;
  assign cpu_reset         = cpu_reset_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign words_loaded      = words_q;
  assign checksum          = sum_q;

endmodule

// File: tb/tb_dmem_boot_ctrl.sv
// Directed bench for dmem_boot_ctrl; memory writes are checked against a scoreboard queue.
module tb_dmem_boot_ctrl;

  localparam int SETTLE_CYCLES = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] len;
  logic [31:0] base_addr;
  logic        abort;
  logic        halt;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;
  logic [31:0] checksum;

  dmem_boot_ctrl_if bus_if ();

  dmem_boot_ctrl dut (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start),
    .len          (len),
    .base_addr    (base_addr),
    .abort        (abort),
    .halt         (halt),
    .bus          (bus_if),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .checksum     (checksum)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  wr_t         exp_q[$];
  logic [31:0] exp_base;
  int          exp_cnt;
  logic [31:0] exp_sum;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every observed write must match the oldest expected one, including its cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus_if.ext_memwrite === 1'b1) begin
      checkOutput("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("wr_addr", bus_if.ext_dataadr, e.addr);
        checkOutput("wr_data", bus_if.ext_writedata, e.data);
        checkOutput("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] l, input logic [31:0] b);
    start     = 1'b1;
    len       = l;
    base_addr = b;
    exp_base  = b & ~32'h3;
    exp_cnt   = 0;
    exp_sum   = '0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic acceptWord(input logic [31:0] d);
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = d;
    exp_q.push_back('{addr: exp_base + 32'(exp_cnt) * 32'd4, data: d, cyc: cyc + 1});
    exp_cnt++;
    exp_sum += d;
    @(negedge clk);
    bus_if.s_valid = 1'b0;
  endtask

  task automatic waitRun();
    for (int i = 0; i < SETTLE_CYCLES - 1; i++) begin
      @(negedge clk);
      checkOutput("settle_done", 32'(done), 32'd0);
      checkOutput("settle_cpu_reset", 32'(cpu_reset), 32'd1);
    end
    @(negedge clk);
    checkOutput("run_done", 32'(done), 32'd1);
    checkOutput("run_cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("run_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("run_done_pulse", 32'(done), 32'd0);
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic doHalt();
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    checkOutput("halt_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("halt_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    len            = '0;
    base_addr      = '0;
    abort          = 1'b0;
    halt           = 1'b0;
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;
    exp_base       = '0;
    exp_cnt        = 0;
    exp_sum        = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("rst_s_ready", 32'(bus_if.s_ready), 32'd0);
    checkOutput("rst_memwrite", 32'(bus_if.ext_memwrite), 32'd0);
    checkOutput("rst_dataadr", bus_if.ext_dataadr, 32'd0);
    checkOutput("rst_writedata", bus_if.ext_writedata, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_words", 32'(words_loaded), 32'd0);
    checkOutput("rst_checksum", checksum, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] basic load");
    applyStimulus(16'd3, 32'h0000_0010);
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_s_ready", 32'(bus_if.s_ready), 32'd1);
    acceptWord(32'h11);
    acceptWord(32'h22);
    acceptWord(32'h33);
    checkOutput("basic_s_ready_drop", 32'(bus_if.s_ready), 32'd0);
    checkOutput("basic_words", 32'(words_loaded), 32'(exp_cnt));
    checkOutput("basic_checksum", checksum, exp_sum);
    checkOutput("basic_checksum_const", checksum, 32'h66);
    waitRun();
    doHalt();

    $display("[TB] stalled stream");
    applyStimulus(16'd2, 32'h0000_0200);
    acceptWord(32'hDEAD_BEEF);
    start = 1'b1;
    len   = 16'd0;
    repeat (5) @(negedge clk);
    start = 1'b0;
    checkOutput("stall_s_ready", 32'(bus_if.s_ready), 32'd1);
    checkOutput("stall_words", 32'(words_loaded), 32'd1);
    acceptWord(32'h1234_5678);
    checkOutput("stall_words_end", 32'(words_loaded), 32'(exp_cnt));
    checkOutput("stall_checksum", checksum, exp_sum);
    waitRun();
    doHalt();

    $display("[TB] zero length");
    applyStimulus(16'd0, 32'h0000_0040);
    checkOutput("zero_s_ready", 32'(bus_if.s_ready), 32'd0);
    checkOutput("zero_busy", 32'(busy), 32'd1);
    waitRun();
    checkOutput("zero_words", 32'(words_loaded), 32'd0);
    checkOutput("zero_checksum", checksum, 32'd0);
    doHalt();

    $display("[TB] abort mid-load");
    applyStimulus(16'd4, 32'h0000_0080);
    acceptWord(32'hA5A5_0001);
    abort          = 1'b1;
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 32'hBAD0_0002;
    #1;
    checkOutput("abort_s_ready", 32'(bus_if.s_ready), 32'd0);
    @(negedge clk);
    abort          = 1'b0;
    bus_if.s_valid = 1'b0;
    checkOutput("abort_err", 32'(err), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("abort_words", 32'(words_loaded), 32'd1);
    checkOutput("abort_checksum", checksum, exp_sum);
    repeat (2) @(negedge clk);
    checkOutput("abort_idle_s_ready", 32'(bus_if.s_ready), 32'd0);
    checkOutput("abort_err_sticky", 32'(err), 32'd1);
    checkOutput("abort_sb_empty", 32'(exp_q.size()), 32'd0);
    applyStimulus(16'd1, 32'h0000_0300);
    checkOutput("restart_err_clear", 32'(err), 32'd0);
    acceptWord(32'h0000_0077);
    waitRun();

    $display("[TB] halt and reload with wrap");
    halt  = 1'b1;
    start = 1'b1;
    len   = 16'd5;
    @(negedge clk);
    halt  = 1'b0;
    start = 1'b0;
    checkOutput("halt_wins_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("halt_wins_busy", 32'(busy), 32'd0);
    applyStimulus(16'd2, 32'hFFFF_FFFC);
    acceptWord(32'hAAAA_0001);
    acceptWord(32'h5555_0002);
    checkOutput("wrap_words", 32'(words_loaded), 32'd2);
    checkOutput("wrap_checksum", checksum, exp_sum);
    waitRun();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
